// File: rtl/gate_pattern_checker.sv
// NAND/NOR gate tester: drives the four input vectors, waits SETTLE cycles, checks the response.
// Define GATE_CHECKER_LOG_EN to capture each sampled response into log.
module gate_pattern_checker #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [7:0] log
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;

    // {NAND, NOR} of the vector's a and b bits
    function automatic logic [1:0] expected_resp(input logic [1:0] v);
        return {~(v[1] & v[0]), ~(v[1] | v[0])};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = 2'd0;
                    err_d   = 3'd0;
                    mask_d  = 4'd0;
                    busy_d  = 1'b1;
                    cnt_d   = SettleLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSample: begin
                if (y_in != expected_resp(idx_q)) begin
                    mask_d[idx_q] = 1'b1;
                    err_d         = err_q + 3'd1;
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = SettleLoad;
                    state_d = StWait;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // done is registered, so the pulse lands on the first IDLE cycle
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == 3'd0);
                idx_d   = 2'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef GATE_CHECKER_LOG_EN
    logic [7:0] log_q, log_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log_q <= 8'h00;
        end else begin
            log_q <= log_d;
        end
    end

    always_comb begin
        log_d = log_q;
        if (state_q == StIdle && start) begin
            log_d = 8'h00;
        end else if (state_q == StSample) begin
            log_d[{idx_q, 1'b0} +: 2] = y_in;
        end
    end

    assign log = log_q;
`else
    assign log = 8'h00;
`endif

    assign a_out     = idx_q[1];
    assign b_out     = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Directed bench for gate_pattern_checker: SETTLE=4 instance for the main passes, SETTLE=1 for timing.
// Log expectations follow GATE_CHECKER_LOG_EN when the bench is built with it.
module tb_gate_pattern_checker;

`ifdef GATE_CHECKER_LOG_EN
    localparam logic [7:0] LogOk  = 8'h2B;
    localparam logic [7:0] LogAll = 8'hFF;
    localparam logic [7:0] LogMid = 8'h0F;
    localparam logic [7:0] LogS1  = 8'h1B;
`else
    localparam logic [7:0] LogOk  = 8'h00;
    localparam logic [7:0] LogAll = 8'h00;
    localparam logic [7:0] LogMid = 8'h00;
    localparam logic [7:0] LogS1  = 8'h00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start4, start1, y_force;
    logic [1:0] y4, y1;
    logic       a4, b4, busy4, done4, pass4;
    logic [2:0] err4;
    logic [3:0] mask4;
    logic [7:0] log4;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] mask1;
    logic [7:0] log1;

    int n_checks = 0;
    int n_errors = 0;

    // Gate-under-test models: good gate (or stuck at 11), and a gate wrong only on vector 2
    assign y4 = y_force ? 2'b11 : {~(a4 & b4), ~(a4 | b4)};
    assign y1 = ({a1, b1} == 2'b10) ? 2'b01 : {~(a1 & b1), ~(a1 | b1)};

    gate_pattern_checker #(.SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .y_in(y4), .a_out(a4), .b_out(b4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_mask(mask4),
        .log(log4)
    );

    gate_pattern_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1), .a_out(a1), .b_out(b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1),
        .log(log1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start sampled at edge 0; records edges (numbered from it) where done is seen high.
    task automatic run_pass(input bit use1, input int restart_at, input bit hold,
                            input int max_edges, output int first_edge, output int last_edge,
                            output int ndone);
        logic d;
        if (use1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", use1 ? busy1 : busy4, 1);
        first_edge = -1;
        last_edge  = -1;
        ndone      = 0;
        for (int n = 1; n <= max_edges; n++) begin
            if (use1) start1 = hold || (n == restart_at);
            else start4 = hold || (n == restart_at);
            @(posedge clk);
            #1;
            d = use1 ? done1 : done4;
            if (d) begin
                ndone++;
                if (first_edge < 0) first_edge = n;
                last_edge = n;
            end
        end
        start4 = 1'b0;
        start1 = 1'b0;
    endtask

    int fe, le, nd;

    initial begin
        rst     = 1'b1;
        start4  = 1'b0;
        start1  = 1'b0;
        y_force = 1'b0;
        #2;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_pass", pass4, 0);
        check("rst_err", err4, 0);
        check("rst_mask", mask4, 0);
        check("rst_log", log4, 0);
        check("rst_ab", {a4, b4}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good gate, single start
        run_pass(0, -1, 0, 30, fe, le, nd);
        check("good_done_edge", fe, 21);
        check("good_done_cnt", nd, 1);
        check("good_pass", pass4, 1);
        check("good_err", err4, 0);
        check("good_mask", mask4, 4'b0000);
        check("good_log", log4, LogOk);
        check("good_busy_end", busy4, 0);

        // Response stuck at 11
        y_force = 1'b1;
        run_pass(0, -1, 0, 30, fe, le, nd);
        y_force = 1'b0;
        check("stuck_done_edge", fe, 21);
        check("stuck_pass", pass4, 0);
        check("stuck_err", err4, 3);
        check("stuck_mask", mask4, 4'b1110);
        check("stuck_log", log4, LogAll);

        // Second start at edge 10 must be ignored
        run_pass(0, 10, 0, 30, fe, le, nd);
        check("restart_done_edge", fe, 21);
        check("restart_done_cnt", nd, 1);
        check("restart_pass", pass4, 1);
        check("restart_err", err4, 0);
        check("restart_mask", mask4, 4'b0000);
        check("restart_log", log4, LogOk);

        // start held high: back-to-back passes
        run_pass(0, -1, 1, 43, fe, le, nd);
        check("hold_first_done", fe, 21);
        check("hold_second_done", le, 43);
        check("hold_done_cnt", nd, 2);
        check("hold_pass", pass4, 1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle_busy", busy4, 0);

        // Reset between edges at edge 12 of a failing pass
        y_force = 1'b1;
        start4  = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        check("mid_busy", busy4, 1);
        check("mid_ab", {a4, b4}, 2'b10);
        check("mid_err", err4, 1);
        check("mid_mask", mask4, 4'b0010);
        check("mid_log", log4, LogMid);
        rst = 1'b1;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_ab", {a4, b4}, 0);
        check("abort_pass", pass4, 0);
        check("abort_err", err4, 0);
        check("abort_mask", mask4, 0);
        check("abort_log", log4, 0);
        y_force = 1'b0;
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done4) nd++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done4) nd++;
        end
        check("abort_no_done", nd, 0);
        run_pass(0, -1, 0, 30, fe, le, nd);
        check("after_rst_done_edge", fe, 21);
        check("after_rst_pass", pass4, 1);
        check("after_rst_err", err4, 0);
        check("after_rst_mask", mask4, 4'b0000);
        check("after_rst_log", log4, LogOk);

        // SETTLE=1, wrong response only on vector 2
        run_pass(1, -1, 0, 20, fe, le, nd);
        check("s1_done_edge", fe, 9);
        check("s1_done_cnt", nd, 1);
        check("s1_mask", mask1, 4'b0100);
        check("s1_err", err1, 1);
        check("s1_pass", pass1, 0);
        check("s1_log", log1, LogS1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_pattern_checker.md
GATE_PATTERN_CHECKER -- requirements
Module: gate_pattern_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4, giving the wait in clock cycles between driving a vector and sampling y_in; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle-or-longer request to run one full test pass.
REQ-005 The block SHALL have port y_in, input, 2 bits: the gate-under-test response, with [1] = NAND(a,b) and [0] = NOR(a,b).
REQ-006 The block SHALL have ports a_out and b_out, output, 1 bit each: the stimulus driven to the gate under test.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a pass.
REQ-009 The block SHALL have port pass, output, 1 bit: the result of the last completed pass.
REQ-010 The block SHALL have port err_count, output, 3 bits: the number of mismatching vectors (0..4).
REQ-011 The block SHALL have port fail_mask, output, 4 bits: bit i set when vector i mismatched.
REQ-012 The block SHALL have port log, output, 8 bits: the captured responses (see Configuration).

Function
REQ-013 The block SHALL use a 2-bit vector index idx, with {a_out,b_out} = idx, so a_out = idx[1] and b_out = idx[0].
REQ-014 The expected response for vector idx SHALL be {~(a&b), ~(a|b)}: 00->11, 01->10, 10->10, 11->00.
REQ-015 The FSM SHALL have the states IDLE, WAIT, SAMPLE and DONE.
REQ-016 IDLE: when start=1 at a clock edge, the block SHALL set idx=0, clear err_count, fail_mask and log, set busy=1, and load the settle counter with SETTLE-1, then go to WAIT.
REQ-017 WAIT: the block SHALL decrement the settle counter each cycle and go to SAMPLE when it reaches 0, so that WAIT lasts exactly SETTLE cycles.
REQ-018 SAMPLE: the block SHALL compare y_in to the expected response; on a mismatch it SHALL set fail_mask[idx] and increment err_count.
REQ-019 SAMPLE, idx<3: the block SHALL increment idx, reload the settle counter, and go to WAIT.
REQ-020 SAMPLE, idx=3: the block SHALL go to DONE.
REQ-021 DONE: the block SHALL assert done=1 for one cycle, clear busy, set pass=(err_count==0), and return to IDLE.
REQ-022 Latency: when start is sampled at edge 0, done SHALL be high during the cycle after edge 4*(SETTLE+1)+1, which is edge 21 for SETTLE=4.
REQ-023 start SHALL be ignored in every state other than IDLE, with no restart and no effect on the current pass.
REQ-024 start held high continuously SHALL begin a new pass on the IDLE cycle that follows DONE.
REQ-025 pass, err_count and fail_mask SHALL hold their values after DONE until the next accepted start.
REQ-026 The comparison SHALL use only the y_in value present in the SAMPLE cycle; y_in in other cycles SHALL be don't-care.

Reset
REQ-027 When rst=1, the block SHALL immediately, without waiting for a clock edge, enter IDLE with idx=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, log=0 and the settle counter at 0.
REQ-028 Reset asserted in the middle of a pass SHALL abort the pass with no done pulse; the next start after rst falls SHALL run a full pass from idx=0.

Configuration
REQ-029 Macro GATE_CHECKER_LOG_EN SHALL control response logging.
REQ-030 With GATE_CHECKER_LOG_EN defined, each SAMPLE SHALL store y_in into log[2*idx+1:2*idx], and log SHALL hold its value until the next accepted start or reset.
REQ-031 Without GATE_CHECKER_LOG_EN, log SHALL be tied to 8'h00, no log storage SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Correct NAND/NOR gate connected, SETTLE=4, one start pulse -> done at edge 21, pass=1, err_count=0, fail_mask=4'b0000; with the macro, log=8'h2B.
REQ-033 y_in forced to 2'b11 -> pass=0, err_count=3, fail_mask=4'b1110; with the macro, log=8'hFF.
REQ-034 start pulsed again at edge 10 of a running pass -> result identical to REQ-032 and only one done pulse.
REQ-035 rst asserted between clock edges at edge 12 of a pass -> outputs go to reset values immediately with no done; a new start then gives the REQ-032 result.
REQ-036 SETTLE=1, y_in wrong only at idx=2 -> done at edge 9, fail_mask=4'b0100, err_count=1, pass=0.
